serial_adder_ctrl: RTL

//   Bit-serial add/subtract unit. Sequences one full_adder cell over a WIDTH-bit

---
 rtl/serial_adder_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit: one full-adder cell walks a WIDTH-bit operand
// pair LSB first, one bit per clock, with a registered carry between bits.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last;

  assign fa_s = opa[0] ^ opb[0] ^ carry;
  assign fa_c = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa      <= '0;
      opb      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_c;
          if (last) begin
            cout     <= fa_c;
            overflow <= fa_c ^ carry;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
